// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: buffers RC4 keystream strobes in a small FIFO and XORs
// each buffered byte with one handshaked data byte (encrypt == decrypt).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ks_valid, ks_byte  one-cycle keystream strobe and byte from the generator
//   din, din_valid     data byte in (valid/ready)
//   din_ready          combinational: keystream buffered and output slot free
//   dout, dout_valid   registered result out (valid/ready)
//   dout_ready         sink ready
//   ks_level           buffered keystream byte count, 0..2**FIFO_AW
//   ks_overflow        sticky: a keystream byte was dropped (FIFO full)
//   byte_count         bytes delivered on dout, wraps at 16 bits
module rc4_stream_xor #(
    parameter int FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ks_valid,
    input  logic [7:0]       ks_byte,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [FIFO_AW:0] ks_level,
    output logic             ks_overflow,
    output logic [15:0]      byte_count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         dout_q, dout_d;
    logic               dv_q, dv_d;
    logic [15:0]        cnt_q, cnt_d;

    logic full;
    logic pop;
    logic push;
    logic fire;
    logic [7:0] head;

    assign full = (level_q == LVL_FULL);
    assign head = mem_q[rd_ptr_q];

    // Only registered state and dout_ready feed din_ready; a byte strobed
    // this cycle is not usable until it is in the FIFO (no bypass).
    assign din_ready = (level_q != '0) && (!dv_q || dout_ready);
    assign pop       = din_valid && din_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still pushes.
    assign push      = ks_valid && (!full || pop);
    assign fire      = dv_q && dout_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        dout_d   = dout_q;
        dv_d     = dv_q;
        cnt_d    = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (ks_valid && full && !pop) begin
            ovf_d = 1'b1;
        end

        // An accept while the previous result drains keeps dout_valid high.
        if (pop) begin
            dout_d = din ^ head;
            dv_d   = 1'b1;
        end else if (fire) begin
            dv_d   = 1'b0;
        end

        if (fire) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            dout_q   <= 8'h00;
            dv_q     <= 1'b0;
            cnt_q    <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only readable once rewritten
    // behind the reset pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ks_byte;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dv_q;
    assign ks_level    = level_q;
    assign ks_overflow = ovf_q;
    assign byte_count  = cnt_q;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Testbench for rc4_stream_xor: directed steps with a scoreboard of
// expected dout bytes and a reference keystream queue.
module tb_rc4_stream_xor;

    logic       clk;
    logic       rst;
    logic       ks_valid;
    logic [7:0] ks_byte;
    logic [7:0] din;
    logic       din_valid;
    logic       tb_rdy;
    logic       chain;

    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic [3:0] ks_level;
    logic       ks_overflow;
    logic [15:0] byte_count;
    logic       a_rdy;

    logic       b_ks_valid;
    logic       b_din_valid;
    logic       b_din_ready;
    logic [7:0] b_dout;
    logic       b_dout_valid;
    logic [3:0] b_ks_level;
    logic       b_ks_overflow;
    logic [15:0] b_byte_count;

    assign a_rdy       = chain ? b_din_ready : tb_rdy;
    assign b_ks_valid  = chain & ks_valid;
    assign b_din_valid = chain & dout_valid;

    rc4_stream_xor #(.FIFO_AW(3)) dut_a (
        .clk(clk), .rst(rst),
        .ks_valid(ks_valid), .ks_byte(ks_byte),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(a_rdy),
        .ks_level(ks_level), .ks_overflow(ks_overflow),
        .byte_count(byte_count)
    );

    rc4_stream_xor #(.FIFO_AW(3)) dut_b (
        .clk(clk), .rst(rst),
        .ks_valid(b_ks_valid), .ks_byte(ks_byte),
        .din(dout), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(tb_rdy),
        .ks_level(b_ks_level), .ks_overflow(b_ks_overflow),
        .byte_count(b_byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ksq [$];
    logic [7:0]  expq [$];
    logic [7:0]  ptq [$];
    logic        ovf_m;
    logic [15:0] cnt_m;
    int          b_out_n;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic kv, input logic [7:0] kb,
                         input logic dv, input logic [7:0] d,
                         input logic rdy);
        ks_valid  = kv;
        ks_byte   = kb;
        din_valid = dv;
        din       = d;
        tb_rdy    = rdy;
    endtask

    task automatic clear_model();
        ksq.delete();
        expq.delete();
        ptq.delete();
        ovf_m   = 1'b0;
        cnt_m   = 16'h0000;
        b_out_n = 0;
    endtask

    // One clock: check registered state against the model at the negedge,
    // score handshakes, update the model, return just after the posedge.
    task automatic tick(output bit acc);
        bit fo;
        bit can_push;
        @(negedge clk);
        chk("ks_level", 32'(ks_level), 32'(ksq.size()));
        chk("ks_overflow", 32'(ks_overflow), 32'(ovf_m));
        chk("byte_count", 32'(byte_count), 32'(cnt_m));
        chk("dout_valid", 32'(dout_valid), 32'(expq.size() != 0));
        chk("din_ready", 32'(din_ready),
            32'((ksq.size() != 0) && (expq.size() == 0 || a_rdy)));
        fo  = dout_valid && a_rdy;
        acc = din_valid && din_ready;
        if (fo) begin
            if (expq.size() == 0) chk("dout_spurious", 32'(1), 32'(0));
            else chk("dout", 32'(dout), 32'(expq.pop_front()));
            cnt_m = cnt_m + 16'd1;
        end
        can_push = (ksq.size() < 8) || acc;
        if (acc) begin
            if (ksq.size() == 0) chk("acc_no_ks", 32'(1), 32'(0));
            else expq.push_back(din ^ ksq[0]);
        end
        if (ks_valid) begin
            if (can_push) ksq.push_back(ks_byte);
            else ovf_m = 1'b1;
        end
        if (acc && ksq.size() != 0) void'(ksq.pop_front());
        if (chain) begin
            if (b_dout_valid && tb_rdy) begin
                if (ptq.size() == 0) chk("rt_spurious", 32'(1), 32'(0));
                else chk("rt_dout", 32'(b_dout), 32'(ptq.pop_front()));
                b_out_n++;
            end
            if (acc) ptq.push_back(din);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_lvl"}, 32'(ks_level), 32'(0));
        chk({tag, "_dv"}, 32'(dout_valid), 32'(0));
        chk({tag, "_ovf"}, 32'(ks_overflow), 32'(0));
        chk({tag, "_cnt"}, 32'(byte_count), 32'(0));
        chk({tag, "_rdy"}, 32'(din_ready), 32'(0));
        chk({tag, "_dout"}, 32'(dout), 32'(0));
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        rst_checks(tag);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit a;
        int pi;
        int ki;
        rst   = 1'b0;
        chain = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        clear_model();
        #1;
        rst = 1'b1;
        #2;
        rst_checks("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic XOR, including no-bypass on the second strobe
        drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1); tick(a);
        drive(1'b0, 8'h00, 1'b1, 8'h00, 1'b1); tick(a);
        chk("basic_acc1", 32'(a), 32'(1));
        chk("basic_dout1", 32'(dout), 32'h5A);
        drive(1'b1, 8'hC3, 1'b1, 8'hFF, 1'b1); tick(a);
        chk("no_bypass", 32'(a), 32'(0));
        drive(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1); tick(a);
        chk("basic_acc2", 32'(a), 32'(1));
        chk("basic_dout2", 32'(dout), 32'h3C);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); tick(a); tick(a);
        chk("basic_cnt", 32'(byte_count), 32'(2));
        chk("basic_lvl", 32'(ks_level), 32'(0));

        // Reset mid-run with level 3 and a pending output
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0); tick(a);
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick(a);
        end
        drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b0); tick(a);
        chk("pre_rst_lvl", 32'(ks_level), 32'(3));
        chk("pre_rst_dv", 32'(dout_valid), 32'(1));
        do_reset("mid_rst");

        // Backpressure
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0, 8'h00, 1'b0); tick(a);
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick(a);
        end
        drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b0); tick(a);
        chk("bp_first", 32'(dout), 32'h31);
        chk("bp_lvl", 32'(ks_level), 32'(2));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b0); tick(a);
            chk("bp_stall", 32'(a), 32'(0));
            chk("bp_hold", 32'(dout), 32'h31);
        end
        drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b1); tick(a);
        chk("bp_release_acc", 32'(a), 32'(1));
        chk("bp_dv", 32'(dout_valid), 32'(1));
        chk("bp_dout2", 32'(dout), 32'h03);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); tick(a); tick(a);
        do_reset("rst2");

        // Fill, overflow, and push coincident with pop when full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b0); tick(a);
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick(a);
        end
        chk("full_lvl", 32'(ks_level), 32'(8));
        chk("full_no_ovf", 32'(ks_overflow), 32'(0));
        drive(1'b1, 8'h99, 1'b0, 8'h00, 1'b0); tick(a);
        chk("ovf_set", 32'(ks_overflow), 32'(1));
        chk("ovf_lvl", 32'(ks_level), 32'(8));
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick(a);
        drive(1'b1, 8'h9A, 1'b1, 8'h0F, 1'b1); tick(a);
        chk("full_pushpop_acc", 32'(a), 32'(1));
        chk("full_pushpop_lvl", 32'(ks_level), 32'(8));
        chk("full_head", 32'(dout), 32'h8F);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); tick(a);
        chk("ovf_sticky", 32'(ks_overflow), 32'(1));
        do_reset("rst3");

        // Round trip through two instances sharing the keystream
        chain = 1'b1;
        pi = 0;
        ki = 0;
        for (int c = 0; c < 200 && b_out_n < 16; c++) begin
            drive((c % 2 == 0) && (ki < 16), 8'(ki + 1),
                  pi < 16, 8'(8'h41 + pi), 1'b1);
            tick(a);
            if (ks_valid) ki++;
            if (a) pi++;
        end
        chk("rt_count", 32'(b_out_n), 32'(16));
        chk("rt_a_ovf", 32'(ks_overflow), 32'(0));
        chk("rt_b_ovf", 32'(b_ks_overflow), 32'(0));
        chk("rt_b_cnt", 32'(b_byte_count), 32'(16));
        chain = 1'b0;
        do_reset("rst4");

        // byte_count wrap after 65535 transfers
        for (int c = 0; c < 70000 && cnt_m != 16'hFFFF; c++) begin
            drive(1'b1, 8'(c), 1'b1, 8'(c >> 8), 1'b1);
            tick(a);
        end
        chk("pre_wrap", 32'(byte_count), 32'hFFFF);
        drive(1'b1, 8'h12, 1'b1, 8'h34, 1'b1); tick(a);
        chk("wrap", 32'(byte_count), 32'h0000);
        chk("wrap_no_ovf", 32'(ks_overflow), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
